// File: rtl/rx_pkg.sv
// Shared types for the RX byte counter slice.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } rx_cnt_state_t;

endpackage

// File: rtl/adder_nbit.sv
// Unsigned BIT_WIDTH-bit adder with carry in; overflow is the carry out.
module adder_nbit #(
    parameter int unsigned BIT_WIDTH = 7
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);

    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/rx_byte_counter.sv
// Counts bytes of one received packet and holds the final length under a valid/ack handshake.
module rx_byte_counter
    import rx_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 7,
    parameter int unsigned MAX_LEN   = 64
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 byte_valid,
    input  logic                 eop,
    input  logic                 count_ack,
    output logic [BIT_WIDTH-1:0] byte_count,
    output logic                 count_valid,
    output logic                 len_err,
    output logic                 busy
);

    localparam logic [BIT_WIDTH-1:0] ZERO      = '0;
    localparam logic [BIT_WIDTH-1:0] ONE       = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH:0]   MAX_LEN_W = (BIT_WIDTH + 1)'(MAX_LEN);
    localparam logic                 ONE_ERR   = (MAX_LEN < 1);

    rx_cnt_state_t        state_q, state_d;
    logic [BIT_WIDTH-1:0] count_q, count_d;
    logic                 err_q, err_d;
    logic                 valid_q;
    logic [BIT_WIDTH-1:0] nxt;
    logic                 ovf;
    logic [BIT_WIDTH-1:0] inc_count;
    logic                 inc_err;

    // The count never wraps: an overflowing increment pins it at all-ones.
    function automatic logic [BIT_WIDTH-1:0] sat_inc(input logic [BIT_WIDTH-1:0] sum,
                                                     input logic                 carry);
        return carry ? {BIT_WIDTH{1'b1}} : sum;
    endfunction

    adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_inc (
        .a        (count_q),
        .b        (ZERO),
        .carry_in (1'b1),
        .sum      (nxt),
        .overflow (ovf)
    );

    always_comb begin
        inc_count = sat_inc(nxt, ovf);
        inc_err   = ovf | ({1'b0, nxt} > MAX_LEN_W);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        if (clear) begin
            state_d = IDLE;
            count_d = ZERO;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eop) begin
                        state_d = HOLD;
                        count_d = byte_valid ? ONE : ZERO;
                        err_d   = 1'b0;
                    end else if (byte_valid) begin
                        state_d = COUNT;
                        count_d = ONE;
                        err_d   = ONE_ERR;
                    end
                end
                COUNT: begin
                    // A byte arriving together with eop is counted before the packet closes.
                    if (byte_valid) begin
                        count_d = inc_count;
                        err_d   = err_q | inc_err;
                    end
                    if (eop) state_d = HOLD;
                end
                HOLD: begin
                    if (count_ack) begin
                        if (eop) begin
                            state_d = HOLD;
                            count_d = byte_valid ? ONE : ZERO;
                            err_d   = 1'b0;
                        end else if (byte_valid) begin
                            state_d = COUNT;
                            count_d = ONE;
                            err_d   = ONE_ERR;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            count_q <= ZERO;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            valid_q <= (state_d == HOLD);
        end
    end

    assign byte_count  = count_q;
    assign count_valid = valid_q;
    assign len_err     = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rx_byte_counter.sv
// Self-checking bench: vector table, directed corner sequences and random stimulus vs. a packet model.
module tb_rx_byte_counter;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear = 1'b0;
    logic       byte_valid = 1'b0;
    logic       eop = 1'b0;
    logic       count_ack = 1'b0;
    logic [6:0] bc7;
    logic       vld7, err7, busy7;
    logic [3:0] bc4;
    logic       vld4, err4, busy4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rx_byte_counter #(.BIT_WIDTH(7), .MAX_LEN(64)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .byte_valid(byte_valid), .eop(eop),
        .count_ack(count_ack), .byte_count(bc7), .count_valid(vld7), .len_err(err7), .busy(busy7)
    );

    rx_byte_counter #(.BIT_WIDTH(4), .MAX_LEN(15)) dut4 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .byte_valid(byte_valid), .eop(eop),
        .count_ack(count_ack), .byte_count(bc4), .count_valid(vld4), .len_err(err4), .busy(busy4)
    );

    // Packet-level model: unbounded byte tally per packet, outputs derived from it.
    bit in_pkt[2];
    bit holding[2];
    int cnt[2];
    int maxv[2] = '{127, 15};
    int mlen[2] = '{64, 15};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            in_pkt[i] = 0; holding[i] = 0; cnt[i] = 0;
        end
    endtask

    task automatic model_step(input bit bv, input bit e, input bit ack, input bit clr);
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                in_pkt[i] = 0; holding[i] = 0; cnt[i] = 0;
            end else if (holding[i]) begin
                if (ack) begin
                    holding[i] = 0;
                    if (e) begin
                        holding[i] = 1; cnt[i] = bv ? 1 : 0;
                    end else if (bv) begin
                        in_pkt[i] = 1; cnt[i] = 1;
                    end
                end
            end else if (in_pkt[i]) begin
                if (bv && cnt[i] < 100000) cnt[i]++;
                if (e) begin
                    in_pkt[i] = 0; holding[i] = 1;
                end
            end else begin
                if (e) begin
                    holding[i] = 1; cnt[i] = bv ? 1 : 0;
                end else if (bv) begin
                    in_pkt[i] = 1; cnt[i] = 1;
                end
            end
        end
    endtask

    function automatic int m_count(input int i);
        return (cnt[i] > maxv[i]) ? maxv[i] : cnt[i];
    endfunction

    function automatic bit m_err(input int i);
        return (cnt[i] > mlen[i]) || (cnt[i] > maxv[i]);
    endfunction

    task automatic check_models();
        chk("w7_count", 32'(bc7), 32'(m_count(0)));
        chk("w7_valid", 32'(vld7), 32'(holding[0]));
        chk("w7_err",   32'(err7), 32'(m_err(0)));
        chk("w7_busy",  32'(busy7), 32'(in_pkt[0] | holding[0]));
        chk("w4_count", 32'(bc4), 32'(m_count(1)));
        chk("w4_valid", 32'(vld4), 32'(holding[1]));
        chk("w4_err",   32'(err4), 32'(m_err(1)));
        chk("w4_busy",  32'(busy4), 32'(in_pkt[1] | holding[1]));
    endtask

    task automatic cycle(input bit bv, input bit e, input bit ack, input bit clr);
        byte_valid = bv; eop = e; count_ack = ack; clear = clr;
        @(posedge clk);
        model_step(bv, e, ack, clr);
        #1;
        check_models();
    endtask

    typedef struct {
        bit bv, e, ack, clr;
        int cnt;
        bit vld, err, busy;
    } vec_t;

    vec_t vecs[21];

    initial begin
        vecs = '{
            '{1,0,0,0, 1,0,0,1}, '{1,0,0,0, 2,0,0,1}, '{1,0,0,0, 3,0,0,1}, '{0,1,0,0, 3,1,0,1},
            '{0,0,0,0, 3,1,0,1}, '{1,1,0,0, 3,1,0,1}, '{0,0,1,0, 3,0,0,0}, '{1,0,0,0, 1,0,0,1},
            '{1,0,0,0, 2,0,0,1}, '{1,1,0,0, 3,1,0,1}, '{1,0,1,0, 1,0,0,1}, '{1,0,0,0, 2,0,0,1},
            '{1,0,0,1, 0,0,0,0}, '{1,0,0,0, 1,0,0,1}, '{0,1,0,0, 1,1,0,1}, '{0,0,0,1, 0,0,0,0},
            '{0,1,0,0, 0,1,0,1}, '{0,1,1,0, 0,1,0,1}, '{1,1,1,0, 1,1,0,1}, '{0,0,1,0, 1,0,0,0},
            '{0,0,1,0, 1,0,0,0}
        };

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(bc7), 0);
        chk("reset_valid", 32'(vld7), 0);
        chk("reset_err",   32'(err7), 0);
        chk("reset_busy",  32'(busy7), 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Vector table on the 7-bit / MAX_LEN=64 instance.
        for (int k = 0; k < 21; k++) begin
            cycle(vecs[k].bv, vecs[k].e, vecs[k].ack, vecs[k].clr);
            chk($sformatf("vec%0d_count", k), 32'(bc7), 32'(vecs[k].cnt));
            chk($sformatf("vec%0d_valid", k), 32'(vld7), 32'(vecs[k].vld));
            chk($sformatf("vec%0d_err", k),   32'(err7), 32'(vecs[k].err));
            chk($sformatf("vec%0d_busy", k),  32'(busy7), 32'(vecs[k].busy));
        end

        // 65-byte packet overruns MAX_LEN; the next short packet starts clean.
        cycle(0, 0, 0, 1);
        repeat (65) cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        chk("long_count", 32'(bc7), 65);
        chk("long_err",   32'(err7), 1);
        chk("long_valid", 32'(vld7), 1);
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        chk("short_count", 32'(bc7), 2);
        chk("short_err",   32'(err7), 0);

        // 17 bytes into the 4-bit instance saturate at 15 instead of wrapping.
        cycle(0, 0, 1, 0);
        repeat (17) cycle(1, 0, 0, 0);
        chk("sat_count", 32'(bc4), 15);
        chk("sat_err",   32'(err4), 1);
        cycle(0, 1, 0, 0);
        chk("sat_final", 32'(bc4), 15);

        // Asynchronous reset mid-packet at count 5.
        cycle(0, 0, 0, 1);
        repeat (5) cycle(1, 0, 0, 0);
        chk("pre_rst_count", 32'(bc7), 5);
        n_rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_count", 32'(bc7), 0);
        chk("async_rst_valid", 32'(vld7), 0);
        chk("async_rst_err",   32'(err7), 0);
        chk("async_rst_busy",  32'(busy7), 0);
        #2;
        n_rst = 1'b1;
        cycle(0, 0, 0, 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(99, 0) < 55, $urandom_range(99, 0) < 8,
                  $urandom_range(99, 0) < 30, $urandom_range(99, 0) < 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
